// File: rtl/bascomp_pkg.sv
// Shared control-unit definitions for the sequence counter.
// Command encodings, default width and the one-hot helper.
package bascomp_pkg;

  localparam int SC_WIDTH_DEFAULT = 4;
  // Widest one-hot vector the helper can build.
  localparam int SC_MAX_STATES = 256;

  typedef enum logic [1:0] {
    SC_CMD_HOLD = 2'd0,
    SC_CMD_CLR  = 2'd1,
    SC_CMD_LOAD = 2'd2,
    SC_CMD_INC  = 2'd3
  } sc_cmd_e;

  function automatic logic [SC_MAX_STATES-1:0] onehot_of(
    input int unsigned count
  );
    return SC_MAX_STATES'(1) << count;
  endfunction

endpackage

// File: rtl/seq_timing_gen_if.sv
// Command/status bundle between the control unit and the counter.
// master drives commands, slave (the counter) returns status.
interface seq_timing_gen_if #(
  parameter int WIDTH = 4,
  parameter int N     = 16
);

  logic             inc;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] seq_count;
  logic [N-1:0]     t_onehot;
  logic             terminal;
  logic             wrapped;
  logic             err_pulse;
  logic             err_sticky;

  modport master (
    output inc, clr, load, load_val,
    input  seq_count, t_onehot, terminal,
    input  wrapped, err_pulse, err_sticky
  );

  modport slave (
    input  inc, clr, load, load_val,
    output seq_count, t_onehot, terminal,
    output wrapped, err_pulse, err_sticky
  );

endinterface

// File: rtl/seq_onehot_dec.sv
// Count to one-hot decode feeding the timing register.
// Supports up to SC_MAX_STATES timing states.
module seq_onehot_dec
  import bascomp_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH_DEFAULT,
  parameter int N     = (1 << WIDTH)
) (
  input  logic [WIDTH-1:0] count_i,
  output logic [N-1:0]     onehot_o
);

  logic [SC_MAX_STATES-1:0] full;

  // Decode through the shared helper, keep the low N timing bits.
  assign full     = onehot_of(32'(count_i));
  assign onehot_o = full[N-1:0];

  // Bits above N are always zero because the count never exceeds N-1.
  if (N < SC_MAX_STATES) begin : g_hi
    logic unused_hi;
    assign unused_hi = |full[SC_MAX_STATES-1:N];
  end

endmodule

// File: rtl/seq_timing_gen.sv
// Sequence counter and T0..Tn timing generator, falling-edge state.
// clr > load > inc > hold, with conflict/illegal-load error flags.
module seq_timing_gen
  import bascomp_pkg::*;
#(
  parameter int WIDTH     = SC_WIDTH_DEFAULT,
  parameter int MAX_COUNT = (1 << WIDTH) - 1,
  parameter int WRAP_MODE = 1
) (
  input logic               clk,
  input logic               rst_n,
  seq_timing_gen_if.slave   bus
);

  localparam int N = MAX_COUNT + 1;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  sc_cmd_e          cmd;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic             wrapped_q, wrapped_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic             load_bad;
  logic [1:0]       n_cmds;

  // Priority-resolve the command and compute the next count.
  always_comb begin
    cmd       = SC_CMD_HOLD;
    cnt_d     = cnt_q;
    wrapped_d = 1'b0;
    load_bad  = 1'b0;
    if (bus.clr)       cmd = SC_CMD_CLR;
    else if (bus.load) cmd = SC_CMD_LOAD;
    else if (bus.inc)  cmd = SC_CMD_INC;
    unique case (cmd)
      SC_CMD_CLR: cnt_d = '0;
      SC_CMD_LOAD: begin
        if (32'(bus.load_val) <= 32'(MAX_COUNT))
          cnt_d = bus.load_val;
        else
          load_bad = 1'b1;
      end
      SC_CMD_INC: begin
        if (cnt_q != MAX_V) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (WRAP_MODE != 0) begin
          cnt_d     = '0;
          wrapped_d = 1'b1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Error flags: more than one command, or an out-of-range load.
  always_comb begin
    n_cmds = {1'b0, bus.clr} + {1'b0, bus.load}
           + {1'b0, bus.inc};
    err_pulse_d  = (n_cmds > 2'd1) | load_bad;
    err_sticky_d = err_sticky_q | err_pulse_d;
  end

  seq_onehot_dec #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_dec (
    .count_i  (cnt_d),
    .onehot_o (onehot_d)
  );

  // State registers, falling edge so the count settles before rising edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      onehot_q     <= N'(1);
      wrapped_q    <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      onehot_q     <= onehot_d;
      wrapped_q    <= wrapped_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.seq_count  = cnt_q;
  assign bus.t_onehot   = onehot_q;
  assign bus.terminal   = (cnt_q == MAX_V);
  assign bus.wrapped    = wrapped_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_seq_timing_gen.sv
// Bench for seq_timing_gen: three configurations driven in lockstep.
// Expected values come from an arithmetic model of the counter rules.
module tb_seq_timing_gen;

  logic clk;
  logic rst_n;
  logic t_inc, t_clr, t_load;
  logic [3:0] t_val;

  int checks = 0;
  int errors = 0;

  // a: MAX 15 wrap, b: MAX 9 saturate, c: MAX 9 wrap
  int mc[3]    = '{15, 9, 9};
  bit mwrap[3] = '{1'b1, 1'b0, 1'b1};

  int m_seq[3];
  bit m_wr[3];
  bit m_ep[3];
  bit m_es[3];

  logic [23:0] obs[3];

  seq_timing_gen_if #(.WIDTH(4), .N(16)) if_a ();
  seq_timing_gen_if #(.WIDTH(4), .N(10)) if_b ();
  seq_timing_gen_if #(.WIDTH(4), .N(10)) if_c ();

  assign if_a.inc = t_inc;
  assign if_a.clr = t_clr;
  assign if_a.load = t_load;
  assign if_a.load_val = t_val;
  assign if_b.inc = t_inc;
  assign if_b.clr = t_clr;
  assign if_b.load = t_load;
  assign if_b.load_val = t_val;
  assign if_c.inc = t_inc;
  assign if_c.clr = t_clr;
  assign if_c.load = t_load;
  assign if_c.load_val = t_val;

  seq_timing_gen #(.WIDTH(4), .MAX_COUNT(15), .WRAP_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  seq_timing_gen #(.WIDTH(4), .MAX_COUNT(9), .WRAP_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  seq_timing_gen #(.WIDTH(4), .MAX_COUNT(9), .WRAP_MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    obs[0] = {if_a.seq_count, if_a.t_onehot, if_a.terminal,
              if_a.wrapped, if_a.err_pulse, if_a.err_sticky};
    obs[1] = {if_b.seq_count, 16'(if_b.t_onehot), if_b.terminal,
              if_b.wrapped, if_b.err_pulse, if_b.err_sticky};
    obs[2] = {if_c.seq_count, 16'(if_c.t_onehot), if_c.terminal,
              if_c.wrapped, if_c.err_pulse, if_c.err_sticky};
  end

  function automatic logic [23:0] exp_w(int d);
    logic [15:0] oh;
    oh = 16'(1) << m_seq[d];
    return {4'(m_seq[d]), oh, m_seq[d] == mc[d],
            m_wr[d], m_ep[d], m_es[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_seq[d] = 0;
      m_wr[d]  = 1'b0;
      m_ep[d]  = 1'b0;
      m_es[d]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    int n;
    n = int'(t_inc) + int'(t_clr) + int'(t_load);
    for (int d = 0; d < 3; d++) begin
      m_wr[d] = 1'b0;
      m_ep[d] = (n > 1);
      if (t_clr) begin
        m_seq[d] = 0;
      end else if (t_load) begin
        if (int'(t_val) <= mc[d]) m_seq[d] = int'(t_val);
        else m_ep[d] = 1'b1;
      end else if (t_inc) begin
        if (m_seq[d] < mc[d]) begin
          m_seq[d] = m_seq[d] + 1;
        end else if (mwrap[d]) begin
          m_seq[d] = 0;
          m_wr[d]  = 1'b1;
        end
      end
      m_es[d] = m_es[d] | m_ep[d];
    end
  endtask

  task automatic drive(bit i, bit c, bit l, logic [3:0] v);
    t_inc  = i;
    t_clr  = c;
    t_load = l;
    t_val  = v;
    @(negedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== exp_w(d)) begin
        errors++;
        $display("FAIL reset dut%0d got %h exp %h", d, obs[d], exp_w(d));
      end
    end
    checks++;
    if (if_a.t_onehot !== 16'h0001) begin
      errors++;
      $display("FAIL reset_onehot got %h exp 0001", if_a.t_onehot);
    end
    #4 rst_n = 1'b1;
  endtask

  task automatic test_count3();
    repeat (3) drive(1, 0, 0, 0);
    checks++;
    if (if_a.seq_count !== 4'd3 || if_a.t_onehot !== 16'b1000 ||
        if_a.err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL count3 got seq %0d oh %b es %b exp 3 1000 0",
               if_a.seq_count, if_a.t_onehot, if_a.err_sticky);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== exp_w(d)) begin
        errors++;
        $display("FAIL count3 dut%0d got %h exp %h", d, obs[d], exp_w(d));
      end
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 0);
    repeat (15) drive(1, 0, 0, 0);
    checks++;
    if (if_a.seq_count !== 4'd15 || if_a.terminal !== 1'b1) begin
      errors++;
      $display("FAIL wrap_top got seq %0d term %b exp 15 1",
               if_a.seq_count, if_a.terminal);
    end
    drive(1, 0, 0, 0);
    checks++;
    if (if_a.seq_count !== 4'd0 || if_a.wrapped !== 1'b1 ||
        if_a.terminal !== 1'b0) begin
      errors++;
      $display("FAIL wrap_edge got seq %0d wr %b term %b exp 0 1 0",
               if_a.seq_count, if_a.wrapped, if_a.terminal);
    end
    drive(0, 0, 0, 0);
    checks++;
    if (if_a.wrapped !== 1'b0 || if_a.seq_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_pulse got wr %b seq %0d exp 0 0",
               if_a.wrapped, if_a.seq_count);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== exp_w(d)) begin
        errors++;
        $display("FAIL wrap dut%0d got %h exp %h", d, obs[d], exp_w(d));
      end
    end
  endtask

  task automatic test_saturate();
    drive(0, 1, 0, 0);
    for (int k = 0; k < 12; k++) begin
      drive(1, 0, 0, 0);
      checks++;
      if (if_b.wrapped !== 1'b0) begin
        errors++;
        $display("FAIL sat_wrapped step %0d got %b exp 0", k, if_b.wrapped);
      end
    end
    checks++;
    if (if_b.seq_count !== 4'd9 || if_b.terminal !== 1'b1) begin
      errors++;
      $display("FAIL sat_end got seq %0d term %b exp 9 1",
               if_b.seq_count, if_b.terminal);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== exp_w(d)) begin
        errors++;
        $display("FAIL sat dut%0d got %h exp %h", d, obs[d], exp_w(d));
      end
    end
  endtask

  task automatic test_conflict();
    drive(0, 0, 1, 4'd5);
    checks++;
    if (if_a.seq_count !== 4'd5) begin
      errors++;
      $display("FAIL conf_load got %0d exp 5", if_a.seq_count);
    end
    drive(1, 1, 0, 0);
    checks++;
    if (if_a.seq_count !== 4'd0 || if_a.err_pulse !== 1'b1 ||
        if_a.err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL conf_edge got seq %0d ep %b es %b exp 0 1 1",
               if_a.seq_count, if_a.err_pulse, if_a.err_sticky);
    end
    drive(0, 0, 0, 0);
    checks++;
    if (if_a.err_pulse !== 1'b0 || if_a.err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL conf_after got ep %b es %b exp 0 1",
               if_a.err_pulse, if_a.err_sticky);
    end
  endtask

  task automatic test_load();
    drive(0, 0, 1, 4'd7);
    checks++;
    if (if_b.seq_count !== 4'd7 || if_b.err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL load7 got seq %0d ep %b exp 7 0",
               if_b.seq_count, if_b.err_pulse);
    end
    drive(0, 0, 1, 4'd12);
    checks++;
    if (if_b.seq_count !== 4'd7 || if_b.err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL load12 got seq %0d ep %b exp 7 1",
               if_b.seq_count, if_b.err_pulse);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== exp_w(d)) begin
        errors++;
        $display("FAIL load dut%0d got %h exp %h", d, obs[d], exp_w(d));
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 1, 4'd6);
    checks++;
    if (if_a.seq_count !== 4'd6) begin
      errors++;
      $display("FAIL ar_pre got %0d exp 6", if_a.seq_count);
    end
    t_load = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== exp_w(d)) begin
        errors++;
        $display("FAIL async_rst dut%0d got %h exp %h", d, obs[d], exp_w(d));
      end
    end
    #1 rst_n = 1'b1;
    repeat (2) drive(1, 0, 0, 0);
    checks++;
    if (if_a.seq_count !== 4'd2 || if_c.seq_count !== 4'd2) begin
      errors++;
      $display("FAIL ar_resume got %0d/%0d exp 2/2",
               if_a.seq_count, if_c.seq_count);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
            $urandom_range(0, 6) == 0, 4'($urandom_range(0, 15)));
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== exp_w(d)) begin
          errors++;
          $display("FAIL random step %0d dut%0d got %h exp %h",
                   k, d, obs[d], exp_w(d));
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    t_inc  = 1'b0;
    t_clr  = 1'b0;
    t_load = 1'b0;
    t_val  = 4'd0;
    model_reset();
    #1;
    test_reset();
    test_count3();
    test_wrap();
    test_saturate();
    test_conflict();
    test_load();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
